// File: rtl/nios_system_nios2_mul_seq.sv
// nios_system_nios2_mul_seq: 32x32 multiply sequencer over a registered 16x16 cell.
// Optional NIOS2_MUL_SEQ_FAST_MUL_EN: MUL skips the high-half pair and the sign correction.
module nios_system_nios2_mul_seq #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic [15:0] cell_a,
  output logic [15:0] cell_b,
  input  logic [31:0] cell_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] k, nk, op, last;
  logic [31:0] a, b, corr_a, corr_b;
  logic [63:0] acc;
  logic [CELL_LAT-1:0] tv;
  logic [1:0] tk [CELL_LAT];
  logic [5:0] shift;
  logic fast, ret, ret_last, accept;
`ifdef NIOS2_MUL_SEQ_FAST_MUL_EN
  assign fast = op == 2'b00;
`else
  assign fast = 1'b0;
`endif
  assign last = fast ? 2'd2 : 2'd3;
  assign nk = k + 2'd1;
  assign ret = tv[CELL_LAT-1];
  assign ret_last = ret && tk[CELL_LAT-1] == last;
  assign shift = tk[CELL_LAT-1] == 2'd0 ? 6'd0 : tk[CELL_LAT-1] == 2'd3 ? 6'd32 : 6'd16;
  assign accept = state == IDLE && in_valid;
  // Unsigned partial products are corrected into a signed high word
  assign corr_a = op[1] && a[31] ? b : 32'd0;
  assign corr_b = op == 2'b11 && b[31] ? a : 32'd0;
  assign in_ready = state == IDLE && !reset;
  assign out_valid = state == DONE;
  assign out_result = out_valid ? (op == 2'b00 ? acc[31:0] : acc[63:32]) : 32'd0;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = in_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = k == last ? DRAIN : ISSUE;
      DRAIN:   state_nx = ret_last ? (fast ? DONE : CORR) : DRAIN;
      CORR:    state_nx = DONE;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      a <= '0;
      b <= '0;
      op <= '0;
      acc <= '0;
      cell_a <= '0;
      cell_b <= '0;
      tv <= '0;
      for (int i = 0; i < CELL_LAT; i++) tk[i] <= '0;
    end else begin
      state <= state_nx;
      tv[0] <= state == ISSUE;
      tk[0] <= k;
      for (int i = 1; i < CELL_LAT; i++) begin
        tv[i] <= tv[i-1];
        tk[i] <= tk[i-1];
      end
      if (ret) acc <= acc + ({32'd0, cell_p} << shift);
      if (accept) begin
        a <= in_src1;
        b <= in_src2;
        op <= in_op;
        k <= '0;
        acc <= '0;
        cell_a <= in_src1[15:0];
        cell_b <= in_src2[15:0];
      end
      if (state == ISSUE && k != last) begin
        k <= nk;
        cell_a <= nk[0] ? a[31:16] : a[15:0];
        cell_b <= nk[1] ? b[31:16] : b[15:0];
      end
      if (state == CORR) acc[63:32] <= acc[63:32] - corr_a - corr_b;
    end
  end
endmodule

// File: tb/tb_nios_system_nios2_mul_seq.sv
// tb_nios_system_nios2_mul_seq: drives CELL_LAT=1 and CELL_LAT=3 sequencers against an arithmetic model.
module tb_nios_system_nios2_mul_seq;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, sel = 0;
  logic [1:0] op = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic ir1, ov1, ir3, ov3;
  logic [31:0] res1, res3, cp1, cp3;
  logic [15:0] ca1, cb1, ca3, cb3;
  logic [31:0] p1;
  logic [31:0] p3 [3];
  logic ir, ov;
  logic [31:0] res;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  nios_system_nios2_mul_seq #(.CELL_LAT(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(ir1), .in_op(op),
    .in_src1(src1), .in_src2(src2), .cell_a(ca1), .cell_b(cb1), .cell_p(cp1),
    .out_valid(ov1), .out_ready(out_ready), .out_result(res1));
  nios_system_nios2_mul_seq #(.CELL_LAT(3)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(ir3), .in_op(op),
    .in_src1(src1), .in_src2(src2), .cell_a(ca3), .cell_b(cb3), .cell_p(cp3),
    .out_valid(ov3), .out_ready(out_ready), .out_result(res3));
  always @(posedge clk) begin
    p1 <= 32'(ca1) * 32'(cb1);
    p3[0] <= 32'(ca3) * 32'(cb3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign cp1 = p1;
  assign cp3 = p3[2];
  assign ir = sel ? ir3 : ir1;
  assign ov = sel ? ov3 : ov1;
  assign res = sel ? res3 : res1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d got=%h exp=%h", tag, sel ? 3 : 1, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{a[31] & o[1]}}, a};
    eb = {{32{b[31] & (o == 2'b11)}}, b};
    p = ea * eb;
    return o == 2'b00 ? p[31:0] : p[63:32];
  endfunction
  function automatic int lat_exp(input logic [1:0] o);
    int base;
    base = 6;
`ifdef NIOS2_MUL_SEQ_FAST_MUL_EN
    if (o == 2'b00) base = 4;
`endif
    return base + (sel ? 3 : 1);
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke);
    int cyc;
    logic [31:0] r;
    cyc = 0;
    while (!ir && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before", ir, 1);
    op = o;
    src1 = a;
    src2 = b;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    op = 2'($urandom);
    src1 = $urandom;
    src2 = $urandom;
    cyc = 1;
    while (!ov && cyc < 40) begin
      if (poke) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, lat_exp(o));
    chk("result", res, ref_mul(o, a, b));
    r = res;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", ov, 1);
      chk("hold_result", res, r);
      chk("hold_ready", ir, 0);
    end
    out_ready = 1;
    in_valid = poke;
    @(negedge clk);
    out_ready = 0;
    chk("post_ready", ir, 1);
    chk("post_valid", ov, 0);
    in_valid = 0;
  endtask
  task automatic abort_op;
    bit seen;
    op = 2'b01;
    src1 = $urandom;
    src2 = $urandom;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    chk("reset_ready", ir, 0);
    chk("reset_valid", ov, 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen |= ov;
    end
    chk("abort_no_valid", seen, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", ir, 0);
      chk("rst_valid", ov, 0);
      chk("rst_result", res, 0);
      chk("rst_cell", sel ? {ca3, cb3} : {ca1, cb1}, 0);
    end
    sel = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      run_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 0, 0);
      run_op(2'b11, 32'h80000000, 32'h80000000, 0, 0);
      run_op(2'b01, 32'h12340000, 32'h00010000, 0, 0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 1);
      abort_op();
      run_op(2'b01, 32'h00010000, 32'h00010000, 0, 0);
      for (int i = 0; i < 30; i++)
        run_op(2'($urandom), $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nios_system_nios2_mul_seq.md
Name: nios_system_nios2_mul_seq

Overview:
- Multi-cycle sequencer for Nios II multiply instructions (MUL, MULXUU, MULXSU, MULXSS).
- Sits directly upstream of the registered 16x16 unsigned multiplier cell. Splits two 32-bit operands into 16-bit halves, issues four partial-product pairs to the cell, and accumulates the returned 32-bit products into a 64-bit sum.
- Applies a signed correction to the upper word, then returns the selected 32-bit word to the M-stage over a valid/ready handshake.

Parameters:
- CELL_LAT, 1, clock cycles from cell operand presentation to valid cell product; legal range 1..3.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_op  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS; all X ops return the high word.
- in_src1  in  32  operand A.
- in_src2  in  32  operand B.
- cell_a  out  16  operand half to cell dataa.
- cell_b  out  16  operand half to cell datab.
- cell_p  in  32  unsigned cell product, valid CELL_LAT cycles after cell_a/cell_b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  selected result word.

Behaviour:
- Reset values: in_ready=0 while reset is asserted and 1 in the first cycle after release. out_valid=0, out_result=0, cell_a=0, cell_b=0. Accumulator, operand and op registers clear to 0. State is IDLE.
- States: IDLE, ISSUE, DRAIN, CORR, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, the request is accepted (cycle 0): A, B and op are latched; next state ISSUE, issue counter k=0.
  - When in_valid=0, remain in IDLE.
- ISSUE (cycles 1..4, k=0..3):
  - Registered cell_a/cell_b per cycle: k0 A[15:0]*B[15:0]; k1 A[31:16]*B[15:0]; k2 A[15:0]*B[31:16]; k3 A[31:16]*B[31:16].
  - A CELL_LAT-deep tag shift register tracks k and a valid bit.
  - After k3, next state is DRAIN.
- Accumulation: on each tagged return (cycle k+1+CELL_LAT), acc(64) += cell_p << shift. Shift is 0 for k0, 16 for k1/k2, 32 for k3. The add is modulo 2^64.
- DRAIN: wait until the k3 product has been accumulated, then go to CORR.
- CORR (one cycle), applied to acc[63:32] modulo 2^32:
  - If op is MULXSU or MULXSS and A[31]=1, subtract B.
  - If op is MULXSS and B[31]=1, subtract A.
  - MUL and MULXUU: no change.
- DONE:
  - out_valid=1; out_result = acc[31:0] for MUL, acc[63:32] otherwise.
  - out_result is held stable until out_ready=1.
  - On the out_valid&out_ready cycle, go to IDLE; in_ready=1 on the next cycle. No same-cycle re-accept.
- Latency: out_valid first asserts at cycle 6+CELL_LAT after acceptance (7 for CELL_LAT=1).
- Back-pressure: out_ready=0 holds DONE indefinitely. The cell inputs hold their last value.
- in_valid while busy: ignored, in_ready=0.
- Reset mid-operation: immediate abort. All state and in-flight tags are discarded; no out_valid for the aborted request.
- Cell products arriving with no valid tag are ignored.

Optional Feature:
- Macro: NIOS2_MUL_SEQ_FAST_MUL_EN.
- Defined:
  - For op MUL, k3 is not issued and CORR is skipped. The state goes from the last k2 accumulate directly to DONE.
  - out_valid asserts at cycle 4+CELL_LAT (5 for CELL_LAT=1).
  - X ops are unchanged.
- Undefined: all ops use the full 4-pair sequence.

Test Plan:
- MUL, A=0xFFFFFFFF, B=0xFFFFFFFF, CELL_LAT=1 -> out_result=0x00000001; out_valid at cycle 7 (cycle 5 with the macro defined).
- MULXUU, A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFE. MULXSS with the same operands -> 0x00000000.
- MULXSU, A=0xFFFFFFFF, B=0x00000002 -> 0xFFFFFFFF. MULXSS, A=0x80000000, B=0x80000000 -> 0x40000000.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_result is stable and in_ready=0 throughout; in_valid pulses during busy are dropped; in_ready=1 the cycle after the handshake.
- Reset asserted at cycle 3 of a MULXUU -> out_valid never asserts for that op. A following MULXUU, A=0x00010000, B=0x00010000 -> 0x00000001 with normal latency.
- CELL_LAT=3, MULXUU, A=0x12340000, B=0x00010000 -> 0x00001234; out_valid at cycle 9.
